// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner peripheral: register map,
// register bit positions, scanner states and a row-priority helper.
package keypad_pkg;

    localparam int KEY_W = 4;

    localparam int KP_STATUS = 4'h0;
    localparam int KP_DATA   = 4'h2;
    localparam int KP_CTRL   = 4'h4;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_EN_BIT    = 3;
    localparam int ST_CNT_LSB   = 4;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_RELEASE
    } kp_state_e;

    // Index of the lowest-numbered row pulled low (rows are active-low).
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        lowest_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small power-of-two FIFO holding debounced key codes; head is read straight
// from the registered storage so it always reflects committed state.
module key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/peripheral_keypad.sv
// Memory-mapped 4x4 keypad scanner: walks active-low columns, debounces the
// returned rows and queues {col,row} key codes for the CPU to pop.
module peripheral_keypad
    import keypad_pkg::*;
#(
    parameter int tamPro   = 16,
    parameter int tamAddr  = 4,
    parameter int DEPTH    = 4,
    parameter int SCAN_DIV = 5000,
    parameter int DEB_CNT  = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs,
    input  logic               rd,
    input  logic               wr,
    input  logic [tamAddr-1:0] addr,
    input  logic [tamPro-1:0]  din,
    output logic [tamPro-1:0]  dout,
    input  logic [3:0]         rows,
    output logic [3:0]         cols
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [3:0]        r_rows_meta;
    logic [3:0]        r_rows_sync;
    logic              r_enable;
    logic              r_overflow;
    logic [tamPro-1:0] r_dout;

    kp_state_e         r_state, w_state_nx;
    logic [1:0]        r_col, w_col_nx;
    logic [DIV_W-1:0]  r_div, w_div_nx;
    logic [DEB_W-1:0]  r_deb, w_deb_nx;
    logic [KEY_W-1:0]  r_code, w_code_nx;
    logic              w_push;

    logic              w_rd_any, w_wr_any, w_rd_status, w_rd_data, w_wr_ctrl;
    logic              w_flush, w_pop;
    logic [KEY_W-1:0]  w_head;
    logic [CW-1:0]     w_count;
    logic              w_full, w_empty;
    logic [tamPro-1:0] w_status, w_rd_mux;
    logic              w_unused_din;

    // Rows come from mechanical switches with no relation to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows_meta <= 4'hF;
            r_rows_sync <= 4'hF;
        end else begin
            r_rows_meta <= rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    assign w_rd_any     = cs && rd && !wr;
    assign w_wr_any     = cs && wr;
    assign w_rd_status  = w_rd_any && (addr == tamAddr'(KP_STATUS));
    assign w_rd_data    = w_rd_any && (addr == tamAddr'(KP_DATA));
    assign w_wr_ctrl    = w_wr_any && (addr == tamAddr'(KP_CTRL));
    assign w_flush      = w_wr_ctrl && din[CTRL_FLUSH_BIT];
    assign w_pop        = w_rd_data && !w_empty;
    assign w_unused_din = ^din[tamPro-1:2];

    key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (r_code),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_div   <= '0;
            r_deb   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_col   <= w_col_nx;
            r_div   <= w_div_nx;
            r_deb   <= w_deb_nx;
            r_code  <= w_code_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_div_nx   = r_div;
        w_deb_nx   = r_deb;
        w_code_nx  = r_code;
        w_push     = 1'b0;

        if (!r_enable) begin
            w_state_nx = ST_IDLE;
            w_col_nx   = '0;
            w_div_nx   = '0;
            w_deb_nx   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_SCAN;
                    w_col_nx   = '0;
                    w_div_nx   = '0;
                end
                ST_SCAN: begin
                    if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                        w_div_nx = '0;
                        if (r_rows_sync != 4'hF) begin
                            w_code_nx  = {r_col, lowest_low(r_rows_sync)};
                            w_state_nx = ST_DEBOUNCE;
                            w_deb_nx   = '0;
                        end else begin
                            w_col_nx = r_col + 2'd1;
                        end
                    end else begin
                        w_div_nx = r_div + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_rows_sync[r_code[1:0]]) begin
                        w_state_nx = ST_SCAN;
                        w_col_nx   = r_col + 2'd1;
                        w_div_nx   = '0;
                    end else if (r_deb == DEB_W'(DEB_CNT - 1)) begin
                        w_push     = 1'b1;
                        w_state_nx = ST_RELEASE;
                        w_deb_nx   = '0;
                    end else begin
                        w_deb_nx = r_deb + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_rows_sync != 4'hF) begin
                        w_deb_nx = '0;
                    end else if (r_deb == DEB_W'(DEB_CNT - 1)) begin
                        w_state_nx = ST_SCAN;
                        w_col_nx   = r_col + 2'd1;
                        w_div_nx   = '0;
                        w_deb_nx   = '0;
                    end else begin
                        w_deb_nx = r_deb + 1'b1;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign cols = (r_state == ST_IDLE) ? 4'hF : ~(4'b0001 << r_col);

    always_comb begin
        w_status                = '0;
        w_status[ST_EMPTY_BIT]  = w_empty;
        w_status[ST_FULL_BIT]   = w_full;
        w_status[ST_OVF_BIT]    = r_overflow;
        w_status[ST_EN_BIT]     = r_enable;
        w_status                = w_status | (tamPro'(w_count) << ST_CNT_LSB);

        w_rd_mux = '0;
        if (w_rd_status) begin
            w_rd_mux = w_status;
        end else if (w_rd_data && !w_empty) begin
            w_rd_mux = tamPro'({1'b1, w_head});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
            r_dout     <= '0;
        end else begin
            if (w_wr_ctrl) r_enable <= din[CTRL_EN_BIT];
            // A push that the FIFO refuses because it is full is the overflow event.
            if (w_flush) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_any) r_dout <= w_rd_mux;
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_peripheral_keypad.sv
// Directed bench for peripheral_keypad with a fast scan/debounce setting and a
// combinational keypad model that pulls a row low while its column is driven.
module tb_peripheral_keypad;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  rows;
    logic [3:0]  cols;

    logic        key_down;
    logic [1:0]  key_col;
    logic [1:0]  key_row;
    logic [3:0]  bounce_mask;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    peripheral_keypad #(
        .tamPro   (16),
        .tamAddr  (4),
        .DEPTH    (4),
        .SCAN_DIV (4),
        .DEB_CNT  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (cs),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .rows  (rows),
        .cols  (cols)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rows = ((key_down && !cols[key_col]) ? ~(4'b0001 << key_row) : 4'hF) & bounce_mask;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus tasks are entered on a falling edge; the strobe is sampled on the next rising edge.
    task automatic do_write(input logic [3:0] a, input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; din = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; din = '0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = dout;
    endtask

    task automatic press(input logic [3:0] code);
        key_col  = code[3:2];
        key_row  = code[1:0];
        key_down = 1'b1;
        repeat (40) @(negedge clk);
        key_down = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  keys [5];
        logic [3:0]  walk [5];

        keys = '{4'h0, 4'h5, 4'hB, 4'hE, 4'h3};
        walk = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        key_down = 1'b0; key_col = '0; key_row = '0; bounce_mask = 4'hF;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_dout", dout, 16'h0000);
        check("reset_cols", {12'h0, cols}, 16'h000F);
        rst_n = 1'b1;
        @(negedge clk);

        do_read(4'h0, d);
        check("status_after_reset", d, 16'h0001);
        do_read(4'h6, d);
        check("unmapped_read", d, 16'h0000);
        check("cols_idle", {12'h0, cols}, 16'h000F);

        // Enable: first column appears one edge after the write, then each slot lasts 4 cycles.
        do_write(4'h4, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) @(negedge clk);
            else repeat (4) @(negedge clk);
            check($sformatf("cols_walk%0d", i), {12'h0, cols}, {12'h0, walk[i]});
        end

        // Column 1, row 2 -> code 6.
        press(4'h6);
        do_read(4'h0, d);
        check("status_one_key", d, 16'h0018);   // count=1, enable=1, not empty
        do_read(4'h2, d);
        check("data_key6", d, 16'h0016);
        do_read(4'h2, d);
        check("data_empty", d, 16'h0000);

        do_read(4'h0, d);
        check("status_enabled_empty", d, 16'h0009);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'h4; din = 16'h0001;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0; din = '0;
        check("rd_wr_holds_dout", dout, 16'h0009);

        bounce_mask = 4'hE;
        repeat (5) @(negedge clk);
        bounce_mask = 4'hF;
        repeat (20) @(negedge clk);
        do_read(4'h0, d);
        check("bounce_no_push", d, 16'h0009);

        for (int i = 0; i < 5; i++) press(keys[i]);
        do_read(4'h0, d);
        check("status_full_ovf", d, 16'h004E);
        for (int i = 0; i < 4; i++) begin
            do_read(4'h2, d);
            check($sformatf("fifo_order%0d", i), d, 16'h0010 | {12'h0, keys[i]});
        end
        do_write(4'h4, 16'h0003);
        do_read(4'h0, d);
        check("status_after_flush", d, 16'h0009);

        // Two keys queued, then a third whose push lands on the same edge as a DATA pop.
        press(4'h9);
        press(4'hC);
        do_write(4'h4, 16'h0000);
        repeat (5) @(negedge clk);
        key_col = 2'd0; key_row = 2'd1; key_down = 1'b1;
        do_write(4'h4, 16'h0001);
        repeat (12) @(negedge clk);
        do_read(4'h2, d);
        check("pop_with_push_head", d, 16'h0019);
        do_read(4'h0, d);
        check("pop_with_push_count", d, 16'h0028);
        do_read(4'h2, d);
        check("pop_with_push_next", d, 16'h001C);
        do_read(4'h2, d);
        check("pop_with_push_new", d, 16'h0011);
        key_down = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of a debounce window (debounce spans edges 5..13 after enable).
        do_write(4'h4, 16'h0000);
        repeat (5) @(negedge clk);
        key_col = 2'd0; key_row = 2'd3; key_down = 1'b1;
        do_write(4'h4, 16'h0001);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_cols", {12'h0, cols}, 16'h000F);
        check("midreset_dout", dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_read(4'h0, d);
        check("midreset_no_key", d, 16'h0001);
        key_down = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
